// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit seven-segment scanner with dead-time blanking and a digit store
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [6:0] wr_seg,
  input  logic       wr_dp,
  input  logic [7:0] digit_en,
  output logic [7:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  typedef enum logic {DEAD, DRIVE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0][7:0] mem_q, mem_d;
  logic [7:0]      an_n_q, an_n_d;
  logic [6:0]      seg_n_q, seg_n_d;
  logic            dp_n_q, dp_n_d, ft_q, ft_d, wrap, on;
  logic [2:0]      di_q, di_d;
  always_comb begin
    wrap    = int'(cnt_q) == REFRESH_DIV - 1;
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    idx_d   = wrap ? idx_q + 3'd1 : idx_q;
    state_d = int'(cnt_d) < DEAD_CYCLES ? DEAD : DRIVE;
    mem_d   = mem_q;
    if (wr_en) mem_d[wr_addr] = {wr_seg, wr_dp};
    // outputs are a registered image of this cycle's state, so the store read uses mem_q
    on      = state_q == DRIVE && digit_en[idx_q];
    an_n_d  = on ? ~(8'd1 << idx_q) : 8'hFF;
    seg_n_d = on ? mem_q[idx_q][7:1] : 7'h7F;
    dp_n_d  = on ? mem_q[idx_q][0] : 1'b1;
    di_d    = idx_q;
    ft_d    = cnt_q == '0 && idx_q == 3'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DEAD_CYCLES > 0 ? DEAD : DRIVE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      mem_q   <= '1;
      an_n_q  <= 8'hFF;
      seg_n_q <= 7'h7F;
      dp_n_q  <= 1'b1;
      di_q    <= 3'd0;
      ft_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      mem_q   <= mem_d;
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
      dp_n_q  <= dp_n_d;
      di_q    <= di_d;
      ft_q    <= ft_d;
    end
  end
  assign an_n       = an_n_q;
  assign seg_n      = seg_n_q;
  assign dp_n       = dp_n_q;
  assign digit_idx  = di_q;
  assign frame_tick = ft_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized scoreboard bench running two parameterisations side by side
module tb_seg_scan_driver;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, wr_dp = 1'b1;
  logic [2:0] wr_addr = '0;
  logic [6:0] wr_seg = '0;
  logic [7:0] digit_en = 8'hFF;
  logic [7:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, ft_a, ft_b;
  logic [2:0] di_a, di_b;
  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] idx;
    logic       ft;
  } obs_t;
  obs_t       qa[$], qb[$];
  int         checks = 0, errors = 0;
  logic [7:0] store[8];
  int         cyc = 0;
  seg_scan_driver #(.REFRESH_DIV(8), .DEAD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_seg(wr_seg), .wr_dp(wr_dp),
    .digit_en(digit_en), .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a), .digit_idx(di_a), .frame_tick(ft_a));
  seg_scan_driver #(.REFRESH_DIV(4), .DEAD_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_seg(wr_seg), .wr_dp(wr_dp),
    .digit_en(digit_en), .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b), .digit_idx(di_b), .frame_tick(ft_b));
  always #5 clk = ~clk;
  // expected outputs for the next cycle, from elapsed time since reset and the digit store
  function automatic obs_t model(int div, int dead);
    obs_t o;
    int   slot, pos;
    bit   on;
    slot  = (cyc / div) % 8;
    pos   = cyc % div;
    on    = pos >= dead && digit_en[slot];
    o.an  = on ? ~(8'd1 << slot) : 8'hFF;
    o.seg = on ? store[slot][7:1] : 7'h7F;
    o.dp  = on ? store[slot][0] : 1'b1;
    o.idx = 3'(slot);
    o.ft  = cyc % (8 * div) == 0;
    return o;
  endfunction
  task automatic step(input bit r, input bit we, input logic [2:0] a, input logic [6:0] s,
                      input logic d, input logic [7:0] en);
    @(negedge clk);
    rst = r; wr_en = we; wr_addr = a; wr_seg = s; wr_dp = d; digit_en = en;
    if (r) begin
      qa.push_back(obs_t'({8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}));
      qb.push_back(obs_t'({8'hFF, 7'h7F, 1'b1, 3'd0, 1'b0}));
      for (int i = 0; i < 8; i++) store[i] = 8'hFF;
      cyc = 0;
    end else begin
      qa.push_back(model(8, 2));
      qb.push_back(model(4, 0));
      if (we) store[a] = {s, d};
      cyc++;
    end
  endtask
  task automatic chk(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got an=%h seg=%h dp=%b idx=%0d ft=%b want an=%h seg=%h dp=%b idx=%0d ft=%b",
               name, $time, act.an, act.seg, act.dp, act.idx, act.ft, exp.an, exp.seg, exp.dp, exp.idx, exp.ft);
    end
    checks++;
    if ($countones(~act.an) > 1) begin
      errors++;
      $display("FAIL %s_one_anode t=%0t got an=%h want at most one low bit", name, $time, act.an);
    end
  endtask
  always begin
    @(posedge clk);
    #1;
    if (qa.size() > 0) chk("dut_a", {an_a, seg_a, dp_a, di_a, ft_a}, qa.pop_front());
    if (qb.size() > 0) chk("dut_b", {an_b, seg_b, dp_b, di_b, ft_b}, qb.pop_front());
  end
  initial begin
    logic [7:0] en;
    bit         r;
    en = 8'hFF;
    step(1, 0, 3'd0, 7'h00, 1'b0, en);
    step(1, 1, 3'd2, 7'h12, 1'b0, en);
    step(1, 0, 3'd0, 7'h00, 1'b0, en);
    step(0, 1, 3'd0, 7'h01, 1'b1, en);
    repeat (70) step(0, 0, 3'd0, 7'h00, 1'b0, en);
    step(0, 1, 3'd3, 7'h4F, 1'b0, en);
    step(0, 1, 3'd3, 7'h22, 1'b1, en);
    en = 8'b1111_0111;
    repeat (70) step(0, 0, 3'd0, 7'h00, 1'b0, en);
    r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en = $urandom_range(0, 3) == 0 ? 8'($urandom) : 8'hFF;
      r = r ? $urandom_range(0, 1) == 1 : $urandom_range(0, 399) == 0;
      step(r, $urandom_range(0, 2) == 0, 3'($urandom), 7'($urandom), 1'($urandom), en);
    end
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d pending want 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter DEAD_CYCLES, default 2000, meaning all-anodes-off cycles at the start of each slot (legal range 0..REFRESH_DIV-2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 SHALL have port wr_en, input, 1 bit: write strobe, one write per asserted cycle.
REQ-006 SHALL have port wr_addr, input, 3 bits: digit index 0..7 for the write.
REQ-007 SHALL have port wr_seg, input, 7 bits: active-low segment pattern, bit6=A through bit0=G, which is the decoder output order.
REQ-008 SHALL have port wr_dp, input, 1 bit: active-low decimal point for the written digit.
REQ-009 SHALL have port digit_en, input, 8 bits: per-digit enable; 0 blanks that digit.
REQ-010 SHALL have port an_n, output, 8 bits: active-low anode drives, bit i = digit i.
REQ-011 SHALL have port seg_n, output, 7 bits: active-low segments, same bit order as wr_seg.
REQ-012 SHALL have port dp_n, output, 1 bit: active-low decimal point.
REQ-013 SHALL have port digit_idx, output, 3 bits: index of the current slot.
REQ-014 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the start of slot 0.

Function
REQ-015 SHALL hold an 8-entry store of {seg[6:0], dp}; a write with wr_en=1 SHALL update entry wr_addr at the clock edge.
REQ-016 SHALL run a slot counter 0..REFRESH_DIV-1; on reaching REFRESH_DIV-1 it SHALL wrap to 0 and increment digit_idx, with 7 wrapping to 0.
REQ-017 SHALL implement a per-slot FSM with states DEAD and DRIVE: DEAD while slot counter < DEAD_CYCLES, DRIVE otherwise; with DEAD_CYCLES=0, DEAD SHALL never be entered.
REQ-018 In DEAD, an_n SHALL be 8'hFF, seg_n SHALL be 7'h7F and dp_n SHALL be 1.
REQ-019 In DRIVE with digit_en[digit_idx]=1, an_n SHALL have only bit digit_idx low, and seg_n/dp_n SHALL equal the stored entry for digit_idx.
REQ-020 In DRIVE with digit_en[digit_idx]=0, an_n SHALL be 8'hFF and segments/dp SHALL be all 1.
REQ-021 All outputs SHALL be registered: outputs in cycle t+1 reflect the counter, digit_en and store values as they stand in cycle t.
REQ-022 A write to the digit being driven SHALL appear on seg_n/dp_n exactly 2 cycles after the wr_en cycle; other slots SHALL be undisturbed.
REQ-023 Successive writes to the same address in consecutive cycles SHALL resolve to the last write; no write SHALL be dropped.
REQ-024 frame_tick SHALL be 1 for exactly the one cycle in which the registered digit_idx=0 and the registered slot count=0.
REQ-025 At most one anode SHALL be low in any cycle, including across slot transitions.

Reset
REQ-026 While rst=1: store SHALL clear to seg=7'h7F and dp=1; slot counter and digit_idx SHALL be 0; an_n SHALL be 8'hFF; seg_n SHALL be 7'h7F; dp_n and frame_tick SHALL be 0/inactive, i.e. dp_n=1 and frame_tick=0.
REQ-027 rst SHALL take priority over wr_en in the same cycle, and that write SHALL be discarded.
REQ-028 Reset asserted mid-slot SHALL blank all outputs from the next edge; after release, scanning SHALL restart at digit 0 with counter 0 and frame_tick SHALL pulse 1 cycle after release.

Verification (REFRESH_DIV=8, DEAD_CYCLES=2 unless stated)
REQ-029 Reset, then write digit 0 = 7'h01 with dp=1 and digit_en=8'hFF -> in slot 0 cycles 2..7: an_n=8'hFE, seg_n=7'h01; all other digits show an_n low but seg_n=7'h7F.
REQ-030 Full frame -> digit_idx steps 0..7 every 8 cycles; frame_tick pulses every 64 cycles; DEAD windows show an_n=8'hFF; never more than one anode low.
REQ-031 Write digit 3 = 7'h4F during DRIVE of slot 3 -> seg_n changes exactly 2 cycles later; digit 2 readback unchanged.
REQ-032 digit_en=8'b1111_0111 -> in slot 3, an_n=8'hFF and seg_n=7'h7F for the whole slot; other slots are unaffected.
REQ-033 rst asserted at slot 5 cycle 4 together with wr_en to digit 5 -> outputs are blanked next cycle; after release, digit 5 reads 7'h7F and scanning restarts at digit 0.
REQ-034 DEAD_CYCLES=0, REFRESH_DIV=4 -> no all-off cycles except on digits where digit_en=0, and the slot period is 4 cycles.
